ps2_key_sequencer: RTL and testbench
====================================

PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 clk_50MHz  input  1  system clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 char  input  8  scan-code byte from the PS/2 receiver, valid when wrreq=1.
REQ-005 wrreq  input  1  one-cycle strobe: new scan-code byte on char.
REQ-006 ascii  output  8  FIFO head character.
REQ-007 out_valid  output  1  FIFO non-empty; ascii valid.
REQ-008 out_ready  input  1  consumer accepts head when out_valid=1.
REQ-009 overflow  output  1  one-cycle pulse: character dropped, FIFO full.
REQ-010 shift_held  output  1  left (0x12) or right (0x59) shift currently held.
REQ-011 caps_led  output  1  caps-lock toggle state.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Decoder FSM states SHALL be IDLE, BRK, EXT, EXT_BRK; advances only on cycles with wrreq=1.
REQ-014 IDLE: 0xF0 -> BRK; 0xE0 -> EXT; any other byte = make code, processed, stay IDLE.
REQ-015 BRK: any byte = break code, processed, -> IDLE.
REQ-016 EXT: 0xF0 -> EXT_BRK; other byte discarded, -> IDLE. EXT_BRK: byte discarded, -> IDLE.
REQ-017 Make 0x12/0x59 SHALL set the matching shift flag; break of same clears it; shift_held = OR of both flags.
REQ-018 Translation SHALL use Set-2 codes: A-Z (e.g. A=0x1C, Q=0x15, Z=0x1A), 0-9 (e.g. 1=0x16, 0=0x45), space 0x29->0x20, enter 0x5A->0x0D, backspace 0x66->0x08.
REQ-019 Letters SHALL map uppercase when (shift_held XOR caps_led), else lowercase; digits/space/enter/backspace unaffected by shift.
REQ-020 Break codes, unmapped make codes, 0xE0/0xF0 prefixes SHALL produce no FIFO write.
REQ-021 Mapped make code SHALL be written to FIFO in the wrreq cycle; out_valid high the next cycle if FIFO was empty (latency 1).
REQ-022 Typematic repeats (repeated make codes) SHALL each produce one character.
REQ-023 Pop occurs on clock edge with out_valid=1 and out_ready=1; ascii updates to next entry the following cycle.
REQ-024 Write while full with no pop: character dropped, FIFO unchanged, overflow=1 exactly one cycle.
REQ-025 Write while full with simultaneous pop: both succeed, fifo_count stays FIFO_DEPTH, no overflow.
REQ-026 Simultaneous write and pop on empty FIFO: no pop occurs (out_valid=0); write succeeds.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; FIFO order strictly preserved.
REQ-028 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately force FSM=IDLE, FIFO empty, fifo_count=0, out_valid=0, ascii=0x00, overflow=0, shift flags=0, caps_led=0.
REQ-030 Reset mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix; first byte after release decoded from IDLE.
REQ-031 wrreq asserted in the cycle rst_n deasserts SHALL be ignored.

Configuration
REQ-032 Macro PS2_CAPSLOCK_EN defined: make 0x58 toggles caps_led only if caps key not already held; break 0x58 clears held flag (repeats do not re-toggle).
REQ-033 PS2_CAPSLOCK_EN undefined: 0x58 treated as unmapped, caps_led tied 0, no caps state registers.

Verification
REQ-034 Bytes 0x1C -> ascii 0x61 ('a'), out_valid next cycle; bytes 0xF0,0x1C -> no write.
REQ-035 0x12, 0x1C, 0xF0, 0x12, 0x1C -> FIFO holds 0x41 then 0x61; shift_held 1 then 0.
REQ-036 0xE0, 0x1C, then 0x1A -> only 0x7A written; FSM back in IDLE after 0x1C.
REQ-037 out_ready=0, FIFO_DEPTH+1 makes of 0x16 -> fifo_count=FIFO_DEPTH, one overflow pulse; drain yields FIFO_DEPTH x 0x31.
REQ-038 (PS2_CAPSLOCK_EN) 0x58, 0x58, 0xF0, 0x58, 0x15 -> caps_led=1 (single toggle), ascii 0x51; with macro undefined -> 0x71.
REQ-039 Full FIFO, out_ready=1 and wrreq with 0x45 same cycle -> count unchanged, overflow=0, 0x30 last entry; rst_n pulse after 0xF0 then 0x29 -> 0x20 written.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// -----------------------------------------------------------------------------
// ps2_key_sequencer
//
// This block turns PS/2 Set-2 scan-code bytes into ASCII characters and queues
// them in a small output FIFO.
//   - A prefix decoder FSM (IDLE/BRK/EXT/EXT_BRK) separates make codes, break
//     codes (0xF0 prefix) and extended codes (0xE0 prefix). Extended keys are
//     discarded.
//   - The block tracks left/right shift. Letters become upper case when
//     shift XOR caps-lock is true.
//   - Each mapped make code, including typematic repeats, writes one character
//     into a FIFO_DEPTH-entry FIFO. If the FIFO is full and no pop happens in
//     the same cycle, the character is dropped and overflow pulses for one
//     cycle.
//
// Optional feature: define PS2_CAPSLOCK_EN to add caps-lock handling. When the
// macro is undefined, 0x58 is an unmapped code and caps_led is tied to 0.
//
// Ports
//   clk_50MHz   in   system clock, all logic on the rising edge
//   rst_n       in   asynchronous active-low reset
//   char[7:0]   in   scan-code byte, valid when wrreq=1
//   wrreq       in   one-cycle strobe for a new byte on char
//   ascii[7:0]  out  FIFO head character (0x00 when the FIFO is empty)
//   out_valid   out  FIFO is non-empty
//   out_ready   in   consumer takes the head when out_valid=1
//   overflow    out  one-cycle pulse when a character is dropped
//   shift_held  out  left or right shift is held
//   caps_led    out  caps-lock toggle state
//   fifo_count  out  current FIFO occupancy
// -----------------------------------------------------------------------------
module ps2_key_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_50MHz,
  input  logic                          rst_n,
  input  logic [7:0]                    char,
  input  logic                          wrreq,
  output logic [7:0]                    ascii,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overflow,
  output logic                          shift_held,
  output logic                          caps_led,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
`ifdef PS2_CAPSLOCK_EN
  localparam logic [7:0] SC_CAPS    = 8'h58;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_t;

  typedef struct packed {
    logic       mapped;
    logic       letter;
    logic [7:0] code;     // lower-case ASCII for letters
  } xlate_t;

  // Set-2 make code to ASCII. Letters are returned in lower case. The caller
  // converts them to upper case when needed.
  function automatic xlate_t xlate(input logic [7:0] sc);
    xlate_t r;
    r = '{mapped: 1'b1, letter: 1'b1, code: 8'h00};
    case (sc)
      8'h1C: r.code = 8'h61;  8'h32: r.code = 8'h62;  8'h21: r.code = 8'h63;
      8'h23: r.code = 8'h64;  8'h24: r.code = 8'h65;  8'h2B: r.code = 8'h66;
      8'h34: r.code = 8'h67;  8'h33: r.code = 8'h68;  8'h43: r.code = 8'h69;
      8'h3B: r.code = 8'h6A;  8'h42: r.code = 8'h6B;  8'h4B: r.code = 8'h6C;
      8'h3A: r.code = 8'h6D;  8'h31: r.code = 8'h6E;  8'h44: r.code = 8'h6F;
      8'h4D: r.code = 8'h70;  8'h15: r.code = 8'h71;  8'h2D: r.code = 8'h72;
      8'h1B: r.code = 8'h73;  8'h2C: r.code = 8'h74;  8'h3C: r.code = 8'h75;
      8'h2A: r.code = 8'h76;  8'h1D: r.code = 8'h77;  8'h22: r.code = 8'h78;
      8'h35: r.code = 8'h79;  8'h1A: r.code = 8'h7A;
      default: begin
        r.letter = 1'b0;
        case (sc)
          8'h45: r.code = 8'h30;  8'h16: r.code = 8'h31;  8'h1E: r.code = 8'h32;
          8'h26: r.code = 8'h33;  8'h25: r.code = 8'h34;  8'h2E: r.code = 8'h35;
          8'h36: r.code = 8'h36;  8'h3D: r.code = 8'h37;  8'h3E: r.code = 8'h38;
          8'h46: r.code = 8'h39;
          8'h29: r.code = 8'h20;  // space
          8'h5A: r.code = 8'h0D;  // enter
          8'h66: r.code = 8'h08;  // backspace
          default: r.mapped = 1'b0;
        endcase
      end
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic            lshift_q, lshift_d;
  logic            rshift_q, rshift_d;
  logic            rst_done_q, rst_done_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem [FIFO_DEPTH];
`ifdef PS2_CAPSLOCK_EN
  logic            caps_led_q, caps_led_d;
  logic            caps_held_q, caps_held_d;
`endif

  logic            caps_state;
  logic            wr_en;
  logic            push;
  logic [7:0]      push_data;
  logic            do_push;
  logic            pop;
  logic            full;
  xlate_t          xl;

`ifdef PS2_CAPSLOCK_EN
  assign caps_state = caps_led_q;
`else
  assign caps_state = 1'b0;
`endif

  // A byte strobed on the first edge after reset release is ignored.
  // rst_done_q becomes 1 only after that first edge.
  assign wr_en = wrreq & rst_done_q;
  assign xl    = xlate(char);

  // ---------------------------------------------------------------------------
  // Prefix decoder and key-state tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
    push       = 1'b0;
    push_data  = 8'h00;
    rst_done_d = 1'b1;
`ifdef PS2_CAPSLOCK_EN
    caps_led_d  = caps_led_q;
    caps_held_d = caps_held_q;
`endif

    if (wr_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (char == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (char == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            // Make code. Shift and caps are modifier keys. Every mapped key,
            // including repeats, queues one character.
            if (char == SC_LSHIFT) lshift_d = 1'b1;
            if (char == SC_RSHIFT) rshift_d = 1'b1;
`ifdef PS2_CAPSLOCK_EN
            if (char == SC_CAPS) begin
              // Toggle only on the first make. Typematic repeats do not toggle.
              if (!caps_held_q) caps_led_d = ~caps_led_q;
              caps_held_d = 1'b1;
            end
`endif
            push      = xl.mapped;
            push_data = (xl.letter && (shift_held ^ caps_state))
                        ? (xl.code - 8'h20) : xl.code;
          end
        end
        ST_BRK: begin
          if (char == SC_LSHIFT) lshift_d = 1'b0;
          if (char == SC_RSHIFT) rshift_d = 1'b0;
`ifdef PS2_CAPSLOCK_EN
          if (char == SC_CAPS) caps_held_d = 1'b0;
`endif
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          state_d = (char == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO control
  // ---------------------------------------------------------------------------
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = (count_q != '0) && out_ready;
  // A push into a full FIFO is accepted when the same edge pops the head.
  assign do_push = push && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = push && full && !pop;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge no matter how the statements are
    // ordered.
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      rst_done_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef PS2_CAPSLOCK_EN
      caps_led_q  <= 1'b0;
      caps_held_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      rst_done_q <= rst_done_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef PS2_CAPSLOCK_EN
      caps_led_q  <= caps_led_d;
      caps_held_q <= caps_held_d;
`endif
    end
  end

  // NOTE: the FIFO storage has no reset. The head is masked while the FIFO is
  // empty, so stale contents are never visible.
  always_ff @(posedge clk_50MHz) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid  = (count_q != '0);
  assign ascii      = out_valid ? mem[rd_ptr_q] : 8'h00;
  assign overflow   = overflow_q;
  assign shift_held = lshift_q | rshift_q;
  assign caps_led   = caps_state;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for ps2_key_sequencer with FIFO_DEPTH = 4.
// The caps-lock expectations follow PS2_CAPSLOCK_EN, the same macro that
// configures the design.
// -----------------------------------------------------------------------------
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;

  logic       clk_50MHz = 1'b0;
  logic       rst_n;
  logic [7:0] char;
  logic       wrreq;
  logic [7:0] ascii;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       shift_held;
  logic       caps_led;
  logic [$clog2(DEPTH):0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .char       (char),
    .wrreq      (wrreq),
    .ascii      (ascii),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .shift_held (shift_held),
    .caps_led   (caps_led),
    .fifo_count (fifo_count)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one rising edge, then return at the next
  // falling edge, where the post-edge state is sampled.
  task automatic send(input logic [7:0] b);
    @(negedge clk_50MHz);
    char  = b;
    wrreq = 1'b1;
    @(negedge clk_50MHz);
    wrreq = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk_50MHz);
    out_ready = 1'b1;
    @(negedge clk_50MHz);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    char      = 8'h00;
    wrreq     = 1'b0;
    out_ready = 1'b0;

    // Reset values
    #5;
    check("rst_count",    32'(fifo_count), 0);
    check("rst_valid",    32'(out_valid),  0);
    check("rst_ascii",    32'(ascii),      0);
    check("rst_overflow", 32'(overflow),   0);
    check("rst_shift",    32'(shift_held), 0);
    check("rst_caps",     32'(caps_led),   0);

    // A byte strobed together with reset release is ignored.
    @(negedge clk_50MHz);
    rst_n = 1'b1;
    char  = 8'h1C;
    wrreq = 1'b1;
    @(negedge clk_50MHz);
    wrreq = 1'b0;
    check("rel_wrreq_count", 32'(fifo_count), 0);
    check("rel_wrreq_valid", 32'(out_valid),  0);

    // Make 0x1C gives 'a' one cycle later.
    send(8'h1C);
    check("a_valid", 32'(out_valid),  1);
    check("a_ascii", 32'(ascii),      32'h61);
    check("a_count", 32'(fifo_count), 1);
    pop_one();
    check("a_popped", 32'(fifo_count), 0);

    // A break code writes nothing.
    send(8'hF0);
    send(8'h1C);
    check("break_nowrite", 32'(fifo_count), 0);

    // Shift held, then released.
    send(8'h12);
    check("shift_on", 32'(shift_held), 1);
    send(8'h1C);
    send(8'hF0);
    send(8'h12);
    check("shift_off", 32'(shift_held), 0);
    send(8'h1C);
    check("shift_count", 32'(fifo_count), 2);
    check("shift_head0", 32'(ascii),      32'h41);
    pop_one();
    check("shift_head1", 32'(ascii),      32'h61);
    pop_one();

    // An extended code is discarded, and the decoder returns to IDLE.
    send(8'hE0);
    send(8'h1C);
    send(8'h1A);
    check("ext_count", 32'(fifo_count), 1);
    check("ext_ascii", 32'(ascii),      32'h7A);
    pop_one();

    // out_ready while empty has no effect.
    pop_one();
    check("ready_empty", 32'(fifo_count), 0);

    // A write and out_ready in the same cycle on an empty FIFO: the write wins.
    @(negedge clk_50MHz);
    char      = 8'h16;
    wrreq     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk_50MHz);
    wrreq     = 1'b0;
    out_ready = 1'b0;
    check("wr_pop_empty_count", 32'(fifo_count), 1);
    check("wr_pop_empty_ascii", 32'(ascii),      32'h31);
    pop_one();

    // Fill the FIFO, then overflow it.
    for (int i = 0; i < DEPTH; i++) send(8'h16);
    check("full_count",  32'(fifo_count), DEPTH);
    check("full_no_ovf", 32'(overflow),   0);
    send(8'h16);
    check("ovf_pulse", 32'(overflow),   1);
    check("ovf_count", 32'(fifo_count), DEPTH);
    @(negedge clk_50MHz);
    check("ovf_single", 32'(overflow),  0);

    // A write while full, with a simultaneous pop.
    @(negedge clk_50MHz);
    char      = 8'h45;
    wrreq     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk_50MHz);
    wrreq     = 1'b0;
    out_ready = 1'b0;
    check("full_wrpop_count", 32'(fifo_count), DEPTH);
    check("full_wrpop_ovf",   32'(overflow),   0);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_data", 32'(ascii), (i == DEPTH - 1) ? 32'h30 : 32'h31);
      pop_one();
    end
    check("drain_empty", 32'(fifo_count), 0);

    // Typematic repeats, shift with a digit, special keys, unmapped codes.
    send(8'h1C);
    send(8'h1C);
    check("repeat_count", 32'(fifo_count), 2);
    check("repeat_0",     32'(ascii),      32'h61);
    pop_one();
    check("repeat_1",     32'(ascii),      32'h61);
    pop_one();
    send(8'h12);
    send(8'h16);
    send(8'hF0);
    send(8'h12);
    send(8'h66);
    send(8'h5A);
    send(8'h76);
    send(8'hE0);
    send(8'hF0);
    send(8'h1C);
    check("special_count", 32'(fifo_count), 3);
    check("shift_digit",   32'(ascii),      32'h31);
    pop_one();
    check("backspace",     32'(ascii),      32'h08);
    pop_one();
    check("enter",         32'(ascii),      32'h0D);
    pop_one();

    // Caps-lock: make, repeat, break, then 'Q'.
    send(8'h58);
    send(8'h58);
    send(8'hF0);
    send(8'h58);
    send(8'h15);
`ifdef PS2_CAPSLOCK_EN
    check("caps_led", 32'(caps_led), 1);
    check("caps_q",   32'(ascii),    32'h51);
`else
    check("caps_led", 32'(caps_led), 0);
    check("caps_q",   32'(ascii),    32'h71);
`endif
    check("caps_count", 32'(fifo_count), 1);
    pop_one();

    // Reset after a pending 0xF0 clears the prefix and empties the FIFO.
    send(8'h16);
    send(8'hF0);
    @(negedge clk_50MHz);
    rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(fifo_count), 0);
    check("async_rst_valid", 32'(out_valid),  0);
    check("async_rst_ascii", 32'(ascii),      0);
    @(negedge clk_50MHz);
    rst_n = 1'b1;
    send(8'h29);
    check("post_rst_count", 32'(fifo_count), 1);
    check("post_rst_space", 32'(ascii),      32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
